// File: rtl/akuma_motion_ctrl_if.sv
// Control bundle between the key decoder and the Akuma motion controller.
// The master drives the per-frame keys; the slave returns position and pose.
interface akuma_motion_ctrl_if;
   logic       frame_tick;
   logic       move_left;
   logic       move_right;
   logic       punch;
   logic       jump;
   logic [9:0] AkumaX;
   logic [9:0] AkumaY;
   logic [2:0] sprite;
   logic       attack_active;

   modport master (
      output frame_tick, move_left, move_right, punch, jump,
      input  AkumaX, AkumaY, sprite, attack_active
   );

   modport slave (
      input  frame_tick, move_left, move_right, punch, jump,
      output AkumaX, AkumaY, sprite, attack_active
   );
endinterface

// File: rtl/akuma_motion_ctrl.sv
// Akuma per-frame motion and pose controller.
// Handles walking, a timed punch and a gravity jump, updated once per frame.
module akuma_motion_ctrl #(
   parameter int X_START      = 100,
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 576,
   parameter int GROUND_Y     = 400,
   parameter int WALK_STEP    = 4,
   parameter int PUNCH_FRAMES = 12,
   parameter int JUMP_VEL     = 8,
   parameter int GRAVITY      = 1
) (
   input logic Clk,
   input logic Reset,
   akuma_motion_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_STAND = 2'd0,
      ST_PUNCH = 2'd1,
      ST_JUMP  = 2'd2
   } state_t;

   localparam logic [10:0]        XMIN11 = 11'(X_MIN);
   localparam logic [10:0]        XMAX11 = 11'(X_MAX);
   localparam logic [10:0]        STEP11 = 11'(WALK_STEP);
   localparam logic signed [10:0] GY11   = 11'(GROUND_Y);

   state_t            state_q, state_d;
   logic [9:0]        x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic signed [6:0] vy_q, vy_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              pprev_q, pprev_d;
   logic              jprev_q, jprev_d;
   logic [2:0]        sprite_q, sprite_d;
   logic              atk_q, atk_d;

   logic              punch_edge;
   logic              jump_edge;
   logic [10:0]       x_ext;
   logic [10:0]       x_walk;
   logic signed [10:0] ny;

   assign punch_edge = bus.punch & ~pprev_q;
   assign jump_edge  = bus.jump & ~jprev_q;
   assign x_ext      = {1'b0, x_q};
   assign ny         = $signed({1'b0, y_q})
                     - $signed({{4{vy_q[6]}}, vy_q});

   // Walk target with both clamps resolved in 11 bits
   always_comb begin
      x_walk = x_ext;
      if (bus.move_left && !bus.move_right) begin
         if (x_ext >= XMIN11 + STEP11)
            x_walk = x_ext - STEP11;
         else
            x_walk = XMIN11;
      end else if (bus.move_right && !bus.move_left) begin
         if (x_ext + STEP11 > XMAX11)
            x_walk = XMAX11;
         else
            x_walk = x_ext + STEP11;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      vy_d    = vy_q;
      cnt_d   = cnt_q;
      pprev_d = pprev_q;
      jprev_d = jprev_q;
      if (bus.frame_tick) begin
         pprev_d = bus.punch;
         jprev_d = bus.jump;
         unique case (state_q)
            ST_STAND: begin
               x_d = x_walk[9:0];
               if (jump_edge) begin
                  state_d = ST_JUMP;
                  vy_d    = 7'(JUMP_VEL);
               end else if (punch_edge) begin
                  state_d = ST_PUNCH;
                  cnt_d   = 6'(PUNCH_FRAMES - 1);
               end
            end
            ST_PUNCH: begin
               if (cnt_q == 6'd0)
                  state_d = ST_STAND;
               else
                  cnt_d = cnt_q - 6'd1;
            end
            ST_JUMP: begin
               x_d = x_walk[9:0];
               if (ny >= GY11) begin
                  y_d     = GY11[9:0];
                  vy_d    = 7'sd0;
                  state_d = ST_STAND;
               end else begin
                  y_d  = ny[10] ? 10'd0 : ny[9:0];
                  vy_d = vy_q - 7'(GRAVITY);
               end
            end
            default: state_d = ST_STAND;
         endcase
      end
   end

   always_comb begin
      sprite_d = 3'd0;
      atk_d    = 1'b0;
      unique case (state_d)
         ST_PUNCH: begin
            sprite_d = 3'd1;
            atk_d    = 1'b1;
         end
         ST_JUMP:  sprite_d = 3'd2;
         default:  sprite_d = 3'd0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_STAND;
         x_q      <= 10'(X_START);
         y_q      <= 10'(GROUND_Y);
         vy_q     <= 7'sd0;
         cnt_q    <= 6'd0;
         pprev_q  <= 1'b0;
         jprev_q  <= 1'b0;
         sprite_q <= 3'd0;
         atk_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vy_q     <= vy_d;
         cnt_q    <= cnt_d;
         pprev_q  <= pprev_d;
         jprev_q  <= jprev_d;
         sprite_q <= sprite_d;
         atk_q    <= atk_d;
      end
   end

   assign bus.AkumaX        = x_q;
   assign bus.AkumaY        = y_q;
   assign bus.sprite        = sprite_q;
   assign bus.attack_active = atk_q;

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// Directed-vector bench for the Akuma motion controller.
// Expected positions and poses are hand-computed for default parameters.
module tb_akuma_motion_ctrl;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   akuma_motion_ctrl_if bus();

   akuma_motion_ctrl dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ylist [17] = '{392, 385, 379, 374, 370, 367, 365, 364, 364,
                      365, 367, 370, 374, 379, 385, 392, 400};

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic l, input logic r,
                       input logic p, input logic j);
      bus.move_left  = l;
      bus.move_right = r;
      bus.punch      = p;
      bus.jump       = j;
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic pose(input string tag, input int x,
                       input int y, input int sp, input int atk);
      chk({tag, " x"}, int'(bus.AkumaX), x);
      chk({tag, " y"}, int'(bus.AkumaY), y);
      chk({tag, " sprite"}, int'(bus.sprite), sp);
      chk({tag, " atk"}, int'(bus.attack_active), atk);
   endtask

   initial begin
      int x;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      bus.frame_tick = 1'b1;
      bus.move_left  = 1'b0;
      bus.move_right = 1'b1;
      bus.punch      = 1'b0;
      bus.jump       = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.frame_tick = 1'b0;
      bus.move_right = 1'b0;
      @(negedge clk);
      pose("reset", 100, 400, 0, 0);

      repeat (3) tick(0, 0, 0, 0);
      pose("idle", 100, 400, 0, 0);

      for (int i = 1; i <= 10; i++) begin
         tick(0, 1, 0, 0);
         chk("walk_r", int'(bus.AkumaX), 100 + 4 * i);
      end
      repeat (108) tick(0, 1, 0, 0);
      chk("pre_clamp", int'(bus.AkumaX), 572);
      for (int i = 0; i < 3; i++) begin
         tick(0, 1, 0, 0);
         chk("clamp_r", int'(bus.AkumaX), 576);
      end
      tick(1, 1, 0, 0);
      chk("both", int'(bus.AkumaX), 576);
      tick(1, 0, 0, 0);
      chk("walk_l", int'(bus.AkumaX), 572);

      tick(0, 0, 1, 0);
      pose("punch_in", 572, 400, 1, 1);
      for (int i = 2; i <= 12; i++) begin
         tick(1, 0, 1, 0);
         pose("punch_hold", 572, 400, 1, 1);
      end
      tick(1, 0, 1, 0);
      pose("punch_end", 572, 400, 0, 0);
      tick(0, 0, 1, 0);
      pose("no_retrig", 572, 400, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 1, 0);
      pose("punch2_in", 572, 400, 1, 1);
      for (int i = 2; i <= 12; i++) begin
         tick(0, 0, 0, i == 5);
         chk("punch2_sp", int'(bus.sprite), 1);
      end
      tick(0, 0, 0, 0);
      pose("punch2_end", 572, 400, 0, 0);
      tick(0, 0, 0, 0);
      pose("jdrop", 572, 400, 0, 0);

      tick(0, 0, 0, 1);
      pose("jump_in", 572, 400, 2, 0);
      x = 572;
      for (int i = 0; i < 17; i++) begin
         tick(1, 0, i == 3, 1);
         x -= 4;
         chk("arc_y", int'(bus.AkumaY), ylist[i]);
         chk("arc_x", int'(bus.AkumaX), x);
         chk("arc_sp", int'(bus.sprite), i == 16 ? 0 : 2);
      end
      tick(0, 0, 0, 0);
      pose("landed", 504, 400, 0, 0);

      tick(0, 0, 1, 1);
      pose("both_edges", 504, 400, 2, 0);
      for (int i = 0; i < 8; i++) tick(0, 0, 0, 1);
      chk("apex", int'(bus.AkumaY), 364);

      rst = 1'b1;
      bus.frame_tick = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.frame_tick = 1'b0;
      pose("mid_reset", 100, 400, 0, 0);
      tick(0, 0, 0, 1);
      pose("rejump", 100, 400, 2, 0);
      for (int i = 0; i < 17; i++) begin
         tick(0, 0, 0, 1);
         chk("rearc_y", int'(bus.AkumaY), ylist[i]);
      end
      chk("reland_sp", int'(bus.sprite), 0);
      tick(0, 0, 0, 1);
      pose("one_jump", 100, 400, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule

// File: doc/akuma_motion_ctrl.md
Name: akuma_motion_ctrl

Overview:
- Per-frame movement and pose controller for the Akuma fighter. Sits directly upstream of the Akuma sprite selector.
- Turns decoded keyboard controls into a registered screen position (AkumaX, AkumaY) and a 3-bit pose code (0 stand, 1 punch, 2 jump).
- Runs a stand/punch/jump state machine with walking, a timed punch and a gravity-based jump.
- Exports attack_active for downstream hit detection.

Parameters:
- X_START, 100: AkumaX after reset.
- X_MIN, 0: left clamp for AkumaX.
- X_MAX, 576: right clamp for AkumaX (640 minus sprite width).
- GROUND_Y, 400: AkumaY when on the ground.
- WALK_STEP, 4: pixels moved per frame while a direction is held.
- PUNCH_FRAMES, 12: frames the punch pose is held (1 to 63).
- JUMP_VEL, 8: initial upward velocity in pixels per frame (1 to 31).
- GRAVITY, 1: velocity decrement per frame (1 to 7).

Ports:
- Clk, input, 1: system clock; the single clock domain.
- Reset, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-Clk pulse per video frame (vsync-derived). All state updates happen only on this pulse.
- move_left, input, 1: left key held.
- move_right, input, 1: right key held.
- punch, input, 1: punch key held.
- jump, input, 1: jump key held.
- AkumaX, output, 10: sprite X position.
- AkumaY, output, 10: sprite Y position.
- sprite, output, 3: pose code (0 stand, 1 punch, 2 jump). Codes 3 to 7 are never driven.
- attack_active, output, 1: high while in PUNCH.

Behaviour:
- Clock and reset
  - One clock; reset is synchronous and active-high.
  - Reset wins over a coincident frame_tick.
  - Reset values: AkumaX=X_START, AkumaY=GROUND_Y, sprite=0, attack_active=0, state STAND, vy=0, punch counter=0, edge-history registers=0.
- Timing
  - Inputs are sampled only in cycles where frame_tick=1.
  - All outputs are registered and update in the Clk cycle after the sampling tick (1-cycle latency).
  - With frame_tick low, nothing changes.
- Edge detection
  - punch_prev and jump_prev capture punch and jump on every tick, in every state.
  - punch_edge = punch & ~punch_prev; jump_edge = jump & ~jump_prev.
  - Holding a key never retriggers an action.
  - An edge that arrives while its action is not allowed is discarded, not queued.
- Horizontal motion
  - Applies on ticks in STAND and JUMP; X is frozen in PUNCH.
  - Left only: X = max(X - WALK_STEP, X_MIN).
  - Right only: X = min(X + WALK_STEP, X_MAX).
  - Both or neither: no change.
  - Compute in 11 bits so the clamps never wrap.
- STAND (sprite=0)
  - On a tick, jump_edge goes to JUMP: vy=JUMP_VEL, sprite=2. Y is unchanged on this tick.
  - Otherwise punch_edge goes to PUNCH: counter=PUNCH_FRAMES-1, sprite=1, attack_active=1.
  - Jump takes priority when both edges occur on the same tick.
- PUNCH (sprite=1)
  - Each tick: if counter==0, go to STAND (sprite=0, attack_active=0); else decrement the counter.
  - The pose therefore lasts exactly PUNCH_FRAMES ticks.
  - Jump edges during PUNCH are ignored.
- JUMP (sprite=2)
  - vy is a signed 7-bit velocity. Each tick compute nextY = Y - vy as an 11-bit signed value.
  - If nextY >= GROUND_Y: Y=GROUND_Y, vy=0, go to STAND (sprite=0).
  - Else if nextY < 0: Y=0, vy = vy - GRAVITY.
  - Else: Y=nextY, vy = vy - GRAVITY.
  - Punch edges are ignored in the air. Horizontal control stays active.
- Invariants
  - X_MIN <= AkumaX <= X_MAX.
  - AkumaY <= GROUND_Y.
  - AkumaY == GROUND_Y whenever sprite is 0 or 1.

Test Plan:
- Reset check: assert Reset for 2 cycles together with frame_tick, then deassert -> AkumaX=100, AkumaY=400, sprite=0, attack_active=0. Ticks with no keys held -> no change.
- Walk and clamp: hold right for 10 ticks from X=100 -> X=140. Hold right from X=572 for 3 ticks -> 576, 576, 576. Hold left and right together -> X unchanged.
- Punch timing: punch rises and stays held -> sprite=1 and attack_active=1 for exactly 12 ticks, then sprite=0. Keep holding punch -> no second punch. Release, then press again -> new punch. Left held during the punch -> X frozen.
- Jump arc (defaults): jump edge -> sprite=2.
  - Y over the following ticks: 392, 385, 379, 374, 370, 367, 365, 364, 364, 365, 367, 370, 374, 379, 385, 392, then 400 with sprite=0.
  - Left held throughout the arc -> X decreases 4 per tick.
- Ignored and simultaneous edges:
  - Punch edge mid-jump -> no effect, sprite stays 2.
  - Jump and punch edges on the same STAND tick -> JUMP.
  - Jump edge mid-punch -> dropped; STAND follows the punch.
- Reset mid-operation: assert Reset at the jump apex (Y=364) with frame_tick high -> next cycle Y=400, X=100, sprite=0. A held jump key after reset -> exactly one new jump, because jump_prev was cleared.
